mem_decode_seq: RTL
===================

Name: mem_decode_seq

Overview:
- Sequential, parametrised successor to the M92 CPU address decoder.
- Accepts one CPU memory request at a time and latches the address.
- Decodes the address into one region, translates ROM/RAM regions to SDRAM addresses through NUM_BANKS programmable bank windows, then completes the request.
- Completion comes from an SDRAM req/ack handshake or a per-region local wait counter. Sits between the V33 bus interface and the SDRAM/video/EEPROM slaves.

Parameters:
- NUM_BANKS, 1, number of 128 KB bank windows (1..3).
- BANK_W, 4, width of each bank register; replaces A[19:16].
- LOCAL_WAIT, 1, wait cycles for non-SDRAM regions (0..15).
- SDR_AW, 25, SDRAM address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_bank_mask  in  BANK_W  per-bit bank substitution mask (from board_cfg).
- cfg_alt_map  in  1  0x80000-0x8ffff decodes to pf_vram.
- bank_wr  in  1  bank register write strobe.
- bank_idx  in  2  bank register index.
- bank_data  in  BANK_W  bank register value.
- req  in  1  CPU request; held high until done.
- addr  in  20  CPU byte address.
- wr  in  1  write request.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.
- region  out  8  one-hot {vector,video_ctl,sprite_ctl,buffer,eeprom,ram,pf_vram,rom}; held while busy.
- sdr_req  out  1  SDRAM request, level.
- sdr_ack  in  1  SDRAM completion, one cycle.
- sdr_addr  out  SDR_AW  translated SDRAM address.
- sdr_we  out  1  SDRAM write.
- wp_err  out  1  write-protect violation pulse; only present when WRITE_PROTECT_EN is defined.

Behaviour:
- Reset: state IDLE; all outputs 0; bank registers 0; wait counter 0. Reset asserted mid-transaction drops sdr_req immediately.
- Decode map, evaluated at request acceptance:
  - C0000-CFFFF: rom.
  - D0000-DFFFF: pf_vram.
  - E0000-EFFFF: ram.
  - F0000-F3FFF: eeprom.
  - F8000-F8FFF: buffer.
  - F9000-F900F: sprite_ctl.
  - F9800-F9801: video_ctl.
  - FFFF0-FFFFF: vector.
  - 80000-8FFFF: pf_vram when cfg_alt_map is 1.
  - All other addresses below C0000: rom.
  - Any other address: region 0; completes through the local path.
- Bank windows: window k (k < NUM_BANKS) covers A[19:17] == 5-k.
  - Inside window k, the substituted nibble = (bank[k] & mask) | (A[19:16] & ~mask).
  - Outside all windows, the nibble is A[19:16].
  - bank_idx >= NUM_BANKS: write ignored.
- sdr_addr:
  - rom: {ROM_BASE[24:20], nibble, A[15:0]}.
  - ram: {RAM_BASE[24:16], A[15:0]}.
  - vector: {ROM_BASE[24:20], 16'h7fff, A[3:0]}.
  - ROM_BASE and RAM_BASE come from the package region table.
- FSM:
  - IDLE: req=1 latches addr, wr, decoded region and sdr_addr, then goes to ISSUE.
  - ISSUE: SDRAM regions (rom, ram, vector) assert sdr_req and go to SDR_WAIT. All other regions load the counter with LOCAL_WAIT and go to LOCAL_WAIT.
  - SDR_WAIT: hold sdr_req, sdr_addr and sdr_we stable. sdr_ack goes to DONE and deasserts sdr_req in that same edge.
  - LOCAL_WAIT: count down; go to DONE when the counter is 0 (LOCAL_WAIT=0 means one cycle in this state).
  - DONE: done=1 for one cycle, then IDLE. Region clears on the return to IDLE.
- Latency, local path: req in cycle 0, done in cycle 3+LOCAL_WAIT.
- Latency, SDRAM path: done one cycle after the sdr_ack cycle.
- sdr_ack outside SDR_WAIT is ignored.
- req must be low in the cycle after done. A req still high in IDLE starts a new transaction.
- bank_wr together with an accepted req in the same cycle: the req uses the old bank value. The new value applies from the next cycle. In-flight transactions are never affected by bank writes.
- sdr_we = latched wr.

Optional Feature:
- Macro: WRITE_PROTECT_EN.
- Defined: a write to rom or vector skips SDRAM. The FSM goes ISSUE->DONE, and wp_err pulses together with done. The wp_err port exists.
- Not defined: ROM writes are forwarded to SDRAM with sdr_we=1, and the wp_err port is absent.

Decomposition:
- m92_pkg holds:
  - region one-hot bit indices as localparams.
  - typedef mem_region_t.
  - typedef decode_state_t {IDLE, ISSUE, SDR_WAIT, LOCAL_WAIT, DONE}.
  - the existing board_cfg_t and REGION_CPU_ROM/RAM bases.
- Sub-module mem_region_decode: purely combinational decode of addr, banks and config into region plus sdr_addr. The top level holds the FSM, bank registers and counter.

Test Plan:
- Reset: reset_n low with req=1 -> done, busy, sdr_req and region all 0. Release, hold req low -> stays IDLE.
- bank_wr idx0=3 with mask 4'hF, then read A=0xA1234 -> sdr_addr = {ROM_BASE[24:20], 4'h3, 16'h1234}, sdr_req held until ack delayed 5 cycles, done one cycle after the ack.
- A=0xF9004, LOCAL_WAIT=2 -> region = sprite_ctl one-hot, sdr_req never asserted, done in cycle 5.
- A=0xFFFF8 -> sdr_addr = {ROM_BASE[24:20], 16'h7fff, 4'h8}. With cfg_alt_map=1, A=0x84000 -> pf_vram, no SDRAM access.
- bank_wr idx0=5 in the same cycle as an accepted req to 0xA0000 (old bank 3) -> nibble 3. The next request uses 5. bank_idx=3 with NUM_BANKS=1 -> ignored.
- With WRITE_PROTECT_EN defined, wr=1 to 0xC0010 -> wp_err and done together, no sdr_req. Without the macro -> sdr_req with sdr_we=1.

Source files
------------

// File: rtl/m92_pkg.sv
// Shared types and constants for the M92 memory decode path: region encoding,
// sequencer states, board configuration and the SDRAM region base table.
package m92_pkg;

  localparam int RGN_ROM        = 0;
  localparam int RGN_PF_VRAM    = 1;
  localparam int RGN_RAM        = 2;
  localparam int RGN_EEPROM     = 3;
  localparam int RGN_BUFFER     = 4;
  localparam int RGN_SPRITE_CTL = 5;
  localparam int RGN_VIDEO_CTL  = 6;
  localparam int RGN_VECTOR     = 7;
  localparam int RGN_N          = 8;

  typedef logic [RGN_N-1:0] mem_region_t;

  typedef enum logic [2:0] {IDLE, ISSUE, SDR_WAIT, LOCAL_WAIT, DONE} decode_state_t;

  typedef struct packed {
    logic [3:0] bank_mask;
    logic       alt_map;
  } board_cfg_t;

  localparam logic [24:0] REGION_CPU_ROM = 25'h010_0000;
  localparam logic [24:0] REGION_CPU_RAM = 25'h020_0000;

  // Regions whose accesses complete through the SDRAM handshake.
  function automatic logic is_sdr_region(input mem_region_t r);
    return r[RGN_ROM] | r[RGN_RAM] | r[RGN_VECTOR];
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational CPU address decode: one-hot region plus the SDRAM address
// after bank-window nibble substitution.
module mem_region_decode
  import m92_pkg::*;
#(
  parameter int NUM_BANKS = 1,
  parameter int BANK_W    = 4
) (
  input  logic [19:0]                      addr,
  input  logic [NUM_BANKS-1:0][BANK_W-1:0] banks,
  input  board_cfg_t                       cfg,
  output mem_region_t                      region,
  output logic [24:0]                      sdr_addr
);

  logic [NUM_BANKS-1:0]      win_hit;
  logic [NUM_BANKS-1:0][3:0] win_nib;
  logic [3:0]                nibble;

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_win
    assign win_hit[k] = (addr[19:17] == 3'(5 - k));
    assign win_nib[k] = (4'(banks[k]) & cfg.bank_mask) | (addr[19:16] & ~cfg.bank_mask);
  end

  // Windows never overlap, so at most one hit wins.
  always_comb begin
    nibble = addr[19:16];
    for (int k = 0; k < NUM_BANKS; k++)
      if (win_hit[k]) nibble = win_nib[k];
  end

  always_comb begin
    region = '0;
    if (addr[19:4] == 16'hFFFF)                     region[RGN_VECTOR]     = 1'b1;
    else if (addr[19:16] == 4'hC)                   region[RGN_ROM]        = 1'b1;
    else if (addr[19:16] == 4'hD)                   region[RGN_PF_VRAM]    = 1'b1;
    else if (addr[19:16] == 4'hE)                   region[RGN_RAM]        = 1'b1;
    else if (addr[19:14] == 6'b111100)              region[RGN_EEPROM]     = 1'b1;
    else if (addr[19:12] == 8'hF8)                  region[RGN_BUFFER]     = 1'b1;
    else if (addr[19:4] == 16'hF900)                region[RGN_SPRITE_CTL] = 1'b1;
    else if (addr[19:1] == 19'h7CC00)               region[RGN_VIDEO_CTL]  = 1'b1;
    else if (cfg.alt_map && addr[19:16] == 4'h8)    region[RGN_PF_VRAM]    = 1'b1;
    else if (addr[19:18] != 2'b11)                  region[RGN_ROM]        = 1'b1;
  end

  always_comb begin
    sdr_addr = '0;
    if (region[RGN_ROM])         sdr_addr = {REGION_CPU_ROM[24:20], nibble, addr[15:0]};
    else if (region[RGN_RAM])    sdr_addr = {REGION_CPU_RAM[24:16], addr[15:0]};
    else if (region[RGN_VECTOR]) sdr_addr = {REGION_CPU_ROM[24:20], 16'h7fff, addr[3:0]};
  end

endmodule

// File: rtl/mem_decode_seq.sv
// Sequential M92 CPU memory decoder: latches one request, decodes it and
// completes via SDRAM handshake or local wait. WRITE_PROTECT_EN adds wp_err.
module mem_decode_seq
  import m92_pkg::*;
#(
  parameter int NUM_BANKS  = 1,
  parameter int BANK_W     = 4,
  parameter int LOCAL_WAIT = 1,
  parameter int SDR_AW     = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BANK_W-1:0] cfg_bank_mask,
  input  logic              cfg_alt_map,
  input  logic              bank_wr,
  input  logic [1:0]        bank_idx,
  input  logic [BANK_W-1:0] bank_data,
  input  logic              req,
  input  logic [19:0]       addr,
  input  logic              wr,
  output logic              done,
  output logic              busy,
  output logic [7:0]        region,
  output logic              sdr_req,
  input  logic              sdr_ack,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic              sdr_we
`ifdef WRITE_PROTECT_EN
  ,output logic             wp_err
`endif
);

  decode_state_t                   state;
  logic [NUM_BANKS-1:0][BANK_W-1:0] bank_q;
  logic [3:0]                      cnt;
  board_cfg_t                      cfg;
  mem_region_t                     dec_region;
  logic [24:0]                     dec_sdr_addr;
  logic                            wp_hit;

  assign cfg = '{bank_mask: 4'(cfg_bank_mask), alt_map: cfg_alt_map};

  mem_region_decode #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_dec (
    .addr     (addr),
    .banks    (bank_q),
    .cfg      (cfg),
    .region   (dec_region),
    .sdr_addr (dec_sdr_addr)
  );

`ifdef WRITE_PROTECT_EN
  assign wp_hit = sdr_we && (region[RGN_ROM] || region[RGN_VECTOR]);
`else
  assign wp_hit = 1'b0;
`endif

  // Decode reads bank_q combinationally, so a same-cycle write lands after the
  // accepting edge and only affects later requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= '0;
    end else begin
      for (int k = 0; k < NUM_BANKS; k++)
        if (bank_wr && bank_idx == 2'(k)) bank_q[k] <= bank_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      busy     <= 1'b0;
      region   <= '0;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      sdr_we   <= 1'b0;
      cnt      <= '0;
`ifdef WRITE_PROTECT_EN
      wp_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef WRITE_PROTECT_EN
      wp_err <= 1'b0;
`endif
      case (state)
        IDLE: if (req) begin
          state    <= ISSUE;
          busy     <= 1'b1;
          region   <= dec_region;
          sdr_addr <= SDR_AW'(dec_sdr_addr);
          sdr_we   <= wr;
        end
        ISSUE: begin
          if (wp_hit) begin
            state <= DONE;
            done  <= 1'b1;
`ifdef WRITE_PROTECT_EN
            wp_err <= 1'b1;
`endif
          end else if (is_sdr_region(region)) begin
            state   <= SDR_WAIT;
            sdr_req <= 1'b1;
          end else begin
            state <= m92_pkg::LOCAL_WAIT;
            cnt   <= 4'(LOCAL_WAIT);
          end
        end
        SDR_WAIT: if (sdr_ack) begin
          state   <= DONE;
          sdr_req <= 1'b0;
          done    <= 1'b1;
        end
        m92_pkg::LOCAL_WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          region   <= '0;
          sdr_addr <= '0;
          sdr_we   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
